trap_dispatcher: RTL and testbench

- Trap-entry and trap-return controller for the Hunter_RV32 core; drives the PC redirect into and out of the trap handlers.
- Arbitrates ecall, ebreak and timer requests and redirects fetch to the fixed handler vector.
- Captures mepc and mcause, and on mret redirects fetch back to mepc.
- The handler-active tracker observes the same pc/mret stream; this block initiates the entries and returns that the tracker follows.

---
 rtl/trap_dispatcher_if.sv | 23 ++
 rtl/trap_dispatcher.sv | 102 ++++++++++
 tb/tb_trap_dispatcher.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/trap_dispatcher_if.sv
// Trap dispatcher bus: retire-stage trap requests and PC in, fetch redirect and trap CSRs out.
interface trap_dispatcher_if;
    logic        ecall;
    logic        ebreak;
    logic        timer;
    logic        mret;
    logic [31:0] pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        in_trap;

    modport master (
        output ecall, ebreak, timer, mret, pc,
        input  redirect_valid, redirect_pc, mepc, mcause, in_trap
    );

    modport slave (
        input  ecall, ebreak, timer, mret, pc,
        output redirect_valid, redirect_pc, mepc, mcause, in_trap
    );
endinterface

// File: rtl/trap_dispatcher.sv
// Trap entry/return controller: arbitrates ebreak > ecall > timer, captures mepc/mcause, redirects fetch.
// Optional macro TRAP_TIMER_PENDING_EN latches timer requests seen outside IDLE.
module trap_dispatcher #(
    parameter logic [31:0] ECALL_VEC  = 32'h20,
    parameter logic [31:0] EBREAK_VEC = 32'h30,
    parameter logic [31:0] TIMER_VEC  = 32'h40
) (
    input  logic               clk,
    input  logic               rst,
    trap_dispatcher_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ENTER, HANDLER, RETURN} state_e;

    state_e      state_q, state_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic        timer_req;

`ifdef TRAP_TIMER_PENDING_EN
    logic pending_q, pending_d;

    // Remember timer requests that arrive while busy; drop the flag once a timer trap is taken.
    always_comb begin
        pending_d = pending_q;
        if (state_q != IDLE) begin
            if (bus.timer) pending_d = 1'b1;
        end else if (!bus.ebreak && !bus.ecall && timer_req) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending_q <= 1'b0;
        else      pending_q <= pending_d;
    end

    assign timer_req = bus.timer | pending_q;
`else
    assign timer_req = bus.timer;
`endif

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        case (state_q)
            IDLE: begin
                if (bus.ebreak) begin
                    state_d       = ENTER;
                    mepc_d        = bus.pc + 32'd4;
                    mcause_d      = 32'd3;
                    redirect_pc_d = EBREAK_VEC;
                end else if (bus.ecall) begin
                    state_d       = ENTER;
                    mepc_d        = bus.pc + 32'd4;
                    mcause_d      = 32'd11;
                    redirect_pc_d = ECALL_VEC;
                end else if (timer_req) begin
                    // Interrupts resume at the interrupted instruction itself.
                    state_d       = ENTER;
                    mepc_d        = bus.pc;
                    mcause_d      = 32'h8000_0007;
                    redirect_pc_d = TIMER_VEC;
                end
            end
            ENTER: state_d = HANDLER;
            HANDLER: begin
                if (bus.mret) begin
                    state_d       = RETURN;
                    redirect_pc_d = mepc_q;
                end
            end
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            redirect_pc_q <= 32'd0;
            mepc_q        <= 32'd0;
            mcause_q      <= 32'd0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
        end
    end

    // Outputs decode straight from the state flops, so they carry no input-to-output path.
    assign bus.redirect_valid = (state_q == ENTER) || (state_q == RETURN);
    assign bus.in_trap        = (state_q == ENTER) || (state_q == HANDLER);
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.mepc           = mepc_q;
    assign bus.mcause         = mcause_q;

endmodule

// File: tb/tb_trap_dispatcher.sv
// Testbench for trap_dispatcher: directed test-plan steps then random traffic against an event-timestamp model.
module tb_trap_dispatcher;

`ifdef TRAP_TIMER_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total  = 0;
    int   passed = 0;

    trap_dispatcher_if bus();

    trap_dispatcher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: tracks edge index of the last entry and the last return.
    int          k;
    int          entry_edge;
    int          ret_edge;
    bit          m_active;
    bit          m_pend;
    logic [31:0] m_rpc, m_mepc, m_mcause;

    task automatic model_reset();
        entry_edge = -100;
        ret_edge   = -100;
        m_active   = 1'b0;
        m_pend     = 1'b0;
        m_rpc      = 32'd0;
        m_mepc     = 32'd0;
        m_mcause   = 32'd0;
    endtask

    task automatic model_edge(input bit ec, input bit eb, input bit tm, input bit mr,
                              input logic [31:0] p);
        bit idle_ok;
        k++;
        idle_ok = !m_active && (k != ret_edge + 1);
        if (idle_ok) begin
            if (eb) begin
                m_mepc = p + 32'd4; m_mcause = 32'd3; m_rpc = 32'h30;
                m_active = 1'b1; entry_edge = k;
            end else if (ec) begin
                m_mepc = p + 32'd4; m_mcause = 32'd11; m_rpc = 32'h20;
                m_active = 1'b1; entry_edge = k;
            end else if (tm || (PEND && m_pend)) begin
                m_mepc = p; m_mcause = 32'h8000_0007; m_rpc = 32'h40;
                m_active = 1'b1; entry_edge = k; m_pend = 1'b0;
            end
        end else begin
            if (PEND && tm) m_pend = 1'b1;
            if (m_active && (k != entry_edge + 1) && mr) begin
                m_rpc = m_mepc; m_active = 1'b0; ret_edge = k;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".redirect_valid"}, {31'd0, bus.redirect_valid},
            {31'd0, (k == entry_edge) || (k == ret_edge)});
        chk({tag, ".in_trap"}, {31'd0, bus.in_trap}, {31'd0, m_active});
        chk({tag, ".redirect_pc"}, bus.redirect_pc, m_rpc);
        chk({tag, ".mepc"}, bus.mepc, m_mepc);
        chk({tag, ".mcause"}, bus.mcause, m_mcause);
    endtask

    task automatic step(input string tag, input bit ec, input bit eb, input bit tm,
                        input bit mr, input logic [31:0] p);
        @(negedge clk);
        bus.ecall = ec; bus.ebreak = eb; bus.timer = tm; bus.mret = mr; bus.pc = p;
        @(posedge clk);
        model_edge(ec, eb, tm, mr, p);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        bus.ecall = 1'b0; bus.ebreak = 1'b0; bus.timer = 1'b0; bus.mret = 1'b0; bus.pc = 32'h0;
        k = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // ecall entry, return
        step("ecall", 1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        chk("ecall.rpc", bus.redirect_pc, 32'h20);
        chk("ecall.mepc", bus.mepc, 32'h104);
        chk("ecall.mcause", bus.mcause, 32'd11);
        chk("ecall.rv", {31'd0, bus.redirect_valid}, 32'd1);
        idle("ecall.handler");
        step("ecall.mret", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("ecall.ret_rpc", bus.redirect_pc, 32'h104);
        idle("ecall.idle");

        // ebreak beats ecall; ecall in handler ignored
        step("ebrk", 1'b1, 1'b1, 1'b0, 1'b0, 32'h200);
        chk("ebrk.rpc", bus.redirect_pc, 32'h30);
        chk("ebrk.mcause", bus.mcause, 32'd3);
        idle("ebrk.handler");
        step("ebrk.nest", 1'b1, 1'b0, 1'b0, 1'b0, 32'h500);
        step("ebrk.mret", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("ebrk.ret_rpc", bus.redirect_pc, 32'h204);
        idle("ebrk.idle");
        step("idle_mret", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("idle_mret.rv", {31'd0, bus.redirect_valid}, 32'd0);

        // timer entry and return to interrupted pc
        step("tmr", 1'b0, 1'b0, 1'b1, 1'b0, 32'h300);
        chk("tmr.mcause", bus.mcause, 32'h8000_0007);
        idle("tmr.handler");
        step("tmr.mret", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("tmr.ret_rpc", bus.redirect_pc, 32'h300);
        chk("tmr.in_trap", {31'd0, bus.in_trap}, 32'd0);
        idle("tmr.idle");

        // timer pulse during handler
        step("pend.ecall", 1'b1, 1'b0, 1'b0, 1'b0, 32'h600);
        idle("pend.handler");
        step("pend.tmr", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        idle("pend.tmr_low");
        step("pend.mret", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        idle("pend.idle");
        step("pend.entry", 1'b0, 1'b0, 1'b0, 1'b0, 32'h700);
        chk("pend.entry_rv", {31'd0, bus.redirect_valid}, {31'd0, PEND});
        idle("pend.h2");
        step("pend.mret2", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        idle("pend.done");

        // pc + 4 wraps
        step("wrap", 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
        chk("wrap.mepc", bus.mepc, 32'h0);
        idle("wrap.handler");
        step("wrap.mret", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        idle("wrap.idle");

        // async reset during ENTER
        step("rst.ecall", 1'b1, 1'b0, 1'b0, 1'b0, 32'h800);
        chk("rst.pre_rv", {31'd0, bus.redirect_valid}, 32'd1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rst.mid");
        @(negedge clk);
        bus.ecall = 1'b0;
        rst = 1'b1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] p;
            p = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) p = 32'hFFFF_FFFC;
            step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), p);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
